reg_alu_datapath: RTL
=====================

// Module: reg_alu_datapath
// PURPOSE
// Parametrised register-file + ALU datapath: next generation of the main top's reg/ALU path.
// Accepts one operation per cycle over a valid/ready handshake.
// Second ALU operand is a register or a sign-extended immediate.
// Two-stage pipeline (operand latch, execute/writeback) with full bypass and result back-pressure.
// Sits between the instruction decode/control FSM and the result/flags consumer.
// PARAMETERS
// WIDTH    8  datapath and register width in bits (>=4)
// NREGS    8  number of registers (power of 2, >=2); AW = $clog2(NREGS)
// IMM_W    8  immediate width (<=WIDTH), sign-extended to WIDTH
// ZERO_R0  1  1: register 0 reads as 0 and ignores writes
// PORTS
// clk          in   1       clock, rising edge
// rst          in   1       asynchronous, active-low reset
// op_valid     in   1       operation request
// op_ready     out  1       block can accept the operation this cycle
// opcode       in   4       ALU operation (see BEHAVIOUR)
// alu_src      in   1       1: B = register rs2; 0: B = sext(imm)
// rd/rs1/rs2   in   AW      destination / source A / source B register indices
// imm          in   IMM_W   immediate operand
// res_valid    out  1       result/flags valid
// res_ready    in   1       consumer accepts the result
// result       out  WIDTH   ALU result
// flags        out  4       {N,Z,C,V}
// dbg_addr     in   AW      debug read index (combinational read, no side effects)
// dbg_data     out  WIDTH   register[dbg_addr]
// BEHAVIOUR
// - Reset (rst=0, async): all registers, S1/S2 contents, result and flags = 0; valids = 0.
//   In-flight ops are discarded. op_ready = 1 once rst deasserts.
// - Accept on op_valid && op_ready at a rising edge. Operands are captured into S1 at accept.
// - s2_free = !res_valid || res_ready.
//   op_ready  = s2_free || !s1_valid.
//   S1 advances to S2 when s1_valid && s2_free.
// - Latency: op accepted at edge N -> executes in cycle N..N+1 -> at edge N+1 result and flags
//   latch into S2 (res_valid=1) and regfile[rd] is written.
//   Throughput is 1 op/cycle while res_ready=1.
// - res_valid && !res_ready: S2 holds result/flags stable.
//   S1 holds when full; op_ready drops only when both S1 and S2 are full.
// - Bypass: an accepted op whose rs1/rs2 matches the advancing S1 rd takes the S1 ALU output,
//   not the regfile (no bubble).
//   No bypass when S1 rd=0 and ZERO_R0=1. A stalled S1 cannot coexist with an accept.
// - Regfile write only on S1->S2 advance. Same-edge dbg_addr read returns the old value.
// - Opcodes:
//   0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//   8 SLT (signed, result 0/1), 9 PASSB.
//   10-15: result 0, flags 0, no regfile write, res_valid still asserted.
// - Arithmetic is modulo 2^WIDTH. Shift amount = B[$clog2(WIDTH)-1:0].
//   C = carry-out (ADD), NOT borrow (SUB), 0 otherwise.
//   V = signed overflow (ADD/SUB), 0 otherwise.
//   N = result[WIDTH-1]; Z = (result==0).
// - rd=0 with ZERO_R0=1: result/flags reported, no write.
// TESTING (WIDTH=8, NREGS=8)
// - Release rst after 2 cycles; alu_src=0: ADD r1=r0+sext(8'h05), then ADD r2=r1+sext(8'hFF)
//   back-to-back, res_ready=1 -> results 05 then 04 (C=1), one per cycle, r2 reads 04.
// - Bypass: r1=7F, then ADD r3=r1+r1 (alu_src=1) next cycle
//   -> result FE, flags N=1 V=1 C=0 Z=0, no stall.
// - Back-pressure: res_ready=0 for 3 cycles, issue 3 ops
//   -> first result held stable, op_ready=0 after 2 accepts, no result lost/duplicated on release.
// - SUB r4=r0-r0 -> 00, Z=1 C=1. SRA of 80 by 3 -> F0. SLT 80<01 -> 01. Opcode 12 -> 00, no write.
// - ZERO_R0: ADD r0=r0+sext(05) -> result 05, dbg r0 reads 00, next op using r0 sees 00.
// - Pull rst low mid-stream with S1 and S2 full -> res_valid=0 and all registers 00 immediately,
//   op_ready=1 after release.

Source files
------------

// File: rtl/reg_alu_datapath.sv
// Register file plus ALU in a two-stage pipeline: S1 latches operands at accept,
// S2 holds the executed result/flags while the regfile is written on the S1->S2 advance.
module reg_alu_datapath #(
  parameter int WIDTH   = 8,
  parameter int NREGS   = 8,
  parameter int IMM_W   = 8,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic             alu_src,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [IMM_W-1:0] imm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR   = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA  = 4'd7,
                         OP_SLT = 4'd8, OP_PASSB = 4'd9;

  logic [WIDTH-1:0] rf_q [NREGS];

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [AW-1:0]    s1_rd_q, s1_rd_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic [3:0]       s2_flags_q, s2_flags_d;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the producer
  // keeps its payload stable while valid is high and ready is low.
  logic s2_free, accept, advance;
  assign s2_free  = !s2_valid_q || res_ready;
  assign op_ready = s2_free || !s1_valid_q;
  assign accept   = op_valid && op_ready;
  assign advance  = s1_valid_q && s2_free;

  // ALU on the S1 operands
  logic [WIDTH:0]   add_x, sub_x;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_wr, s1_wr;

  assign add_x = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign sub_x = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt = s1_b_q[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b1;
    case (s1_op_q)
      OP_ADD: begin
        alu_res = add_x[WIDTH-1:0];
        alu_c   = add_x[WIDTH];
        alu_v   = (s1_a_q[MSB] == s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_x[WIDTH-1:0];
        alu_c   = sub_x[WIDTH];
        alu_v   = (s1_a_q[MSB] != s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_AND:   alu_res = s1_a_q & s1_b_q;
      OP_OR:    alu_res = s1_a_q | s1_b_q;
      OP_XOR:   alu_res = s1_a_q ^ s1_b_q;
      OP_SLL:   alu_res = s1_a_q << shamt;
      OP_SRL:   alu_res = s1_a_q >> shamt;
      OP_SRA:   alu_res = $signed(s1_a_q) >>> shamt;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OP_PASSB: alu_res = s1_b_q;
      default:  alu_wr  = 1'b0;
    endcase
  end

  // Undefined opcodes and writes to a hard-wired r0 still report, but never touch the regfile.
  assign s1_wr = alu_wr && !((ZERO_R0 != 0) && (s1_rd_q == '0));

  // Operand read with bypass from the op advancing out of S1 this cycle
  logic [WIDTH-1:0] rf_a, rf_b, imm_sext, op_a, op_b;
  assign rf_a     = ((ZERO_R0 != 0) && (rs1 == '0)) ? '0 : rf_q[rs1];
  assign rf_b     = ((ZERO_R0 != 0) && (rs2 == '0)) ? '0 : rf_q[rs2];
  assign imm_sext = WIDTH'($signed(imm));
  assign op_a     = (advance && s1_wr && (rs1 == s1_rd_q)) ? alu_res : rf_a;
  assign op_b     = !alu_src ? imm_sext :
                    (advance && s1_wr && (rs2 == s1_rd_q)) ? alu_res : rf_b;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = opcode;
      s1_rd_d    = rd;
      s1_a_d     = op_a;
      s1_b_d     = op_b;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    if (advance) begin
      s2_valid_d = 1'b1;
      s2_res_d   = alu_res;
      s2_flags_d = {alu_res[MSB], alu_wr && (alu_res == '0), alu_c, alu_v};
    end else if (res_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_rd_q    <= s1_rd_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (advance && s1_wr) begin
      rf_q[s1_rd_q] <= alu_res;
    end
  end

  assign res_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign flags     = s2_flags_q;
  assign dbg_data  = rf_q[dbg_addr];
endmodule
